fifo_ctrl: RTL and testbench

FIFO_CTRL -- requirements
Module: fifo_ctrl

---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_ptr.sv | 37 +++
 rtl/fifo_ctrl.sv | 120 ++++++++++++
 tb/tb_fifo_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults for the FIFO controller slice.
// No logic; constants and a pointer-width helper only.
// No flow control.
package fifo_pkg;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 4;
  localparam int ADDR_W = 8;
  localparam int PTR_W  = $clog2(DEPTH);

  // Pointer width for a given depth. A depth of 1 still needs one bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping address pointer: counts 0..DEPTH-1, then returns to 0.
// Latency: the pointer advances on the clock edge after i_en is sampled high.
// No backpressure; the caller qualifies i_en.
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset, forces the pointer to 0
//   i_en   in   advance the pointer by one this cycle
//   o_ptr  out  current pointer value
module fifo_ptr #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  output logic [PTR_W-1:0] o_ptr
);

  logic [PTR_W-1:0] r_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_en) begin
      // Explicit wrap so that non-power-of-two depths also work.
      if (r_ptr == PTR_W'(DEPTH - 1)) begin
        r_ptr <= '0;
      end else begin
        r_ptr <= r_ptr + 1'b1;
      end
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller driving an external 2-port RAM (write on edge, registered read).
// Latency: pop request to rd_valid/rd_data is 1 cycle; push is written on the accept edge.
// Backpressure: wr_ready = !full; pops while empty and pushes while full are dropped and flagged.
//
// Ports:
//   clk, rst                         clock and synchronous active-high reset
//   wr_valid, wr_data, wr_ready      push side (accepted when wr_valid && wr_ready)
//   rd_req, rd_valid, rd_data        pop side (rd_data is 0 unless rd_valid)
//   ram_write_en/addr/data           RAM write port
//   ram_read_en/addr, ram_read_data  RAM read port, data returns the cycle after ram_read_en
//   count, full, empty               occupancy status
//   overflow, underflow              one-cycle pulses after a dropped push / pop
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH  = fifo_pkg::DEPTH,
  parameter int DATA_W = fifo_pkg::DATA_W,
  parameter int ADDR_W = fifo_pkg::ADDR_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_valid,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       wr_ready,
  input  logic                       rd_req,
  output logic                       rd_valid,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       ram_write_en,
  output logic [ADDR_W-1:0]          ram_write_addr,
  output logic [DATA_W-1:0]          ram_write_data,
  output logic                       ram_read_en,
  output logic [ADDR_W-1:0]          ram_read_addr,
  input  logic [DATA_W-1:0]          ram_read_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PTR_BITS = ptr_w(DEPTH);
  localparam int CNT_W    = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0]    r_count;
  logic                r_rd_valid;
  logic                r_overflow;
  logic                r_underflow;

  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic [PTR_BITS-1:0] w_wr_ptr;
  logic [PTR_BITS-1:0] w_rd_ptr;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  // Accepts are masked by rst so the RAM sees no strobes during reset.
  // Empty blocks the pop even when a push arrives in the same cycle: no bypass.
  // Full blocks the push even when a pop arrives in the same cycle.
  assign w_push = wr_valid && !w_full  && !rst;
  assign w_pop  = rd_req   && !w_empty && !rst;

  fifo_ptr #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_BITS)
  ) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_push),
    .o_ptr (w_wr_ptr)
  );

  fifo_ptr #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_BITS)
  ) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_pop),
    .o_ptr (w_rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count     <= '0;
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // Read data lands in the RAM output register on the same edge.
      r_rd_valid  <= w_pop;
      r_overflow  <= wr_valid && w_full;
      r_underflow <= rd_req && w_empty;
    end
  end

  assign wr_ready       = !w_full;
  assign full           = w_full;
  assign empty          = w_empty;
  assign count          = r_count;

  assign ram_write_en   = w_push;
  assign ram_write_addr = ADDR_W'(w_wr_ptr);
  assign ram_write_data = wr_data;
  assign ram_read_en    = w_pop;
  assign ram_read_addr  = ADDR_W'(w_rd_ptr);

  assign rd_valid       = r_rd_valid;
  assign rd_data        = r_rd_valid ? ram_read_data : '0;
  assign overflow       = r_overflow;
  assign underflow      = r_underflow;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl with a behavioural 2-port RAM.
// Inputs driven on the falling edge; outputs sampled #1 after edges.
// Scoreboard queue carries expected pop data from accept to rd_valid.
module tb_fifo_ctrl;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 4;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_valid = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_ready;
  logic              rd_req = 1'b0;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              ram_write_en;
  logic [ADDR_W-1:0] ram_write_addr;
  logic [DATA_W-1:0] ram_write_data;
  logic              ram_read_en;
  logic [ADDR_W-1:0] ram_read_addr;
  logic [DATA_W-1:0] ram_read_data = '0;
  logic [3:0]        count;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              underflow;

  always #5 clk = ~clk;

  fifo_ctrl #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_valid       (wr_valid),
    .wr_data        (wr_data),
    .wr_ready       (wr_ready),
    .rd_req         (rd_req),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .ram_write_en   (ram_write_en),
    .ram_write_addr (ram_write_addr),
    .ram_write_data (ram_write_data),
    .ram_read_en    (ram_read_en),
    .ram_read_addr  (ram_read_addr),
    .ram_read_data  (ram_read_data),
    .count          (count),
    .full           (full),
    .empty          (empty),
    .overflow       (overflow),
    .underflow      (underflow)
  );

  // Behavioural RAM: write on edge, registered read.
  logic [DATA_W-1:0] mem [0:255];
  always @(posedge clk) begin
    if (ram_write_en) mem[ram_write_addr] <= ram_write_data;
    if (ram_read_en)  ram_read_data <= mem[ram_read_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model state
  int                m_cnt = 0;
  int                m_wp  = 0;
  int                m_rp  = 0;
  logic              m_rv  = 1'b0;
  logic              m_ov  = 1'b0;
  logic              m_un  = 1'b0;
  logic [DATA_W-1:0] data_q[$];   // FIFO contents
  logic [DATA_W-1:0] exp_q[$];    // expected rd_data, pushed on pop accept

  task automatic step(input logic wv, input logic [DATA_W-1:0] wd,
                      input logic rr, input logic rs);
    logic              e_push;
    logic              e_pop;
    logic [DATA_W-1:0] e_dat;
    @(negedge clk);
    rst      = rs;
    wr_valid = wv;
    wr_data  = wd;
    rd_req   = rr;
    #1;
    e_push = !rs && wv && (m_cnt < DEPTH);
    e_pop  = !rs && rr && (m_cnt > 0);
    chk("wr_ready", wr_ready, (m_cnt != DEPTH));
    chk("ram_write_en", ram_write_en, e_push);
    chk("ram_read_en", ram_read_en, e_pop);
    if (e_push) begin
      chk("ram_write_addr", ram_write_addr, m_wp);
      chk("ram_write_data", ram_write_data, wd);
    end
    if (e_pop) chk("ram_read_addr", ram_read_addr, m_rp);

    @(posedge clk);
    #1;
    if (rs) begin
      m_cnt = 0; m_wp = 0; m_rp = 0;
      m_rv = 1'b0; m_ov = 1'b0; m_un = 1'b0;
      data_q.delete();
      exp_q.delete();
    end else begin
      m_ov = wv && (m_cnt == DEPTH);
      m_un = rr && (m_cnt == 0);
      if (e_pop) begin
        exp_q.push_back(data_q.pop_front());
        m_rp = (m_rp + 1) % DEPTH;
      end
      if (e_push) begin
        data_q.push_back(wd);
        m_wp = (m_wp + 1) % DEPTH;
      end
      if (e_push && !e_pop) m_cnt++;
      if (e_pop && !e_push) m_cnt--;
      m_rv = e_pop;
    end
    chk("count", count, m_cnt);
    chk("full", full, (m_cnt == DEPTH));
    chk("empty", empty, (m_cnt == 0));
    chk("overflow", overflow, m_ov);
    chk("underflow", underflow, m_un);
    chk("rd_valid", rd_valid, m_rv);
    e_dat = '0;
    if (m_rv && exp_q.size() > 0) e_dat = exp_q.pop_front();
    chk("rd_data", rd_data, e_dat);
  endtask

  initial begin
    // Reset
    step(1'b0, 4'h0, 1'b0, 1'b1);
    step(1'b0, 4'h0, 1'b0, 1'b1);
    step(1'b0, 4'h0, 1'b0, 1'b0);

    // Fill with 0x1..0x8, then overflow attempt while full
    for (int i = 1; i <= 8; i++) step(1'b1, 4'(i), 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    step(1'b1, 4'hF, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0);

    // Drain back-to-back, then underflow attempt while empty
    for (int i = 0; i < 8; i++) step(1'b0, 4'h0, 1'b1, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0);

    // Empty with push and pop together: only the push is taken
    step(1'b1, 4'hA, 1'b1, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0);

    // Count 3, then 10 cycles of simultaneous push/pop across the wrap
    for (int i = 0; i < 3; i++) step(1'b1, 4'(i + 3), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 4'(i + 6), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 1'b1, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0);

    // Full with push and pop together: only the pop is taken
    for (int i = 0; i < 8; i++) step(1'b1, 4'(15 - i), 1'b0, 1'b0);
    step(1'b1, 4'h5, 1'b1, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 4'h0, 1'b1, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0);

    // Pop accepted, then reset in the following cycle
    step(1'b1, 4'h7, 1'b0, 1'b0);
    step(1'b1, 4'h9, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b1);
    step(1'b0, 4'h0, 1'b0, 1'b0);

    // Random traffic
    for (int i = 0; i < 200; i++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 49) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
